// File: rtl/dc_dpcm_encoder.sv
// DC DPCM stage: per-component predictor differencing with MCU/restart scheduling and
// JPEG magnitude category, one registered output word per accepted DC coefficient.

module dc_dpcm_pred #(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rst_clr,
  input  logic              sof_clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // A restart boundary clears even the lane that just loaded; sof clears only idle lanes
  always_ff @(posedge clk) begin
    if (reset || rst_clr) q <= '0;
    else if (ld)          q <= d;
    else if (sof_clr)     q <= '0;
  end
endmodule

module dc_dpcm_encoder #(
  parameter int DATA_W       = 11,
  parameter int NUM_COMP     = 3,
  parameter int LUMA_BLOCKS  = 4,
  parameter int RST_INTERVAL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sof,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_dc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_diff,
  output logic [3:0]               out_cat,
  output logic [1:0]               out_comp,
  output logic                     out_rst,
  output logic                     out_mcu_last
);
  localparam int BLK_W = (LUMA_BLOCKS > 1) ? $clog2(LUMA_BLOCKS) : 1;
  localparam int MCU_W = (RST_INTERVAL > 1) ? $clog2(RST_INTERVAL) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(LUMA_BLOCKS - 1);
  localparam logic [1:0]       COMP_LAST = 2'(NUM_COMP - 1);
  localparam logic [MCU_W-1:0] MCU_LAST  = MCU_W'((RST_INTERVAL > 0) ? RST_INTERVAL - 1 : 0);

  logic [NUM_COMP-1:0][DATA_W-1:0] pred;
  logic [BLK_W-1:0] blk_cnt, blk_eff;
  logic [1:0]       comp_cnt, comp_eff;
  logic [MCU_W-1:0] mcu_cnt, mcu_eff;
  logic             rst_pend;
  logic             accept, mcu_last, restart_hit;
  logic [DATA_W-1:0] pred_sel;
  logic [DATA_W:0]   diff, mag;
  logic [3:0]        cat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // sof restarts the schedule for the word that carries it
  assign comp_eff = sof ? 2'd0 : comp_cnt;
  assign blk_eff  = sof ? '0 : blk_cnt;
  assign mcu_eff  = sof ? '0 : mcu_cnt;

  assign mcu_last    = (comp_eff == COMP_LAST) && ((comp_eff != 2'd0) || (blk_eff == BLK_LAST));
  assign restart_hit = (RST_INTERVAL != 0) && mcu_last && (mcu_eff == MCU_LAST);

  always_comb begin
    pred_sel = '0;
    if (!sof)
      for (int i = 0; i < NUM_COMP; i++)
        if (comp_cnt == 2'(i)) pred_sel = pred[i];
  end

  // Sign-extend both operands so the difference always fits in DATA_W+1 bits
  assign diff = {in_dc[DATA_W-1], in_dc} - {pred_sel[DATA_W-1], pred_sel};
  assign mag  = diff[DATA_W] ? (~diff + 1'b1) : diff;

  always_comb begin
    cat = '0;
    for (int i = 0; i <= DATA_W; i++)
      if (mag[i]) cat = 4'(i + 1);
  end

  for (genvar g = 0; g < NUM_COMP; g++) begin : g_lane
    dc_dpcm_pred #(.DATA_W(DATA_W)) u_pred (
      .clk     (clk),
      .reset   (reset),
      .rst_clr (accept && restart_hit),
      .sof_clr (accept && sof),
      .ld      (accept && (comp_eff == 2'(g))),
      .d       (in_dc),
      .q       (pred[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt  <= '0;
      comp_cnt <= '0;
      mcu_cnt  <= '0;
      rst_pend <= 1'b0;
    end else if (accept) begin
      rst_pend <= restart_hit;
      if (mcu_last) begin
        blk_cnt  <= '0;
        comp_cnt <= '0;
        mcu_cnt  <= restart_hit ? '0 : mcu_eff + 1'b1;
      end else if ((comp_eff == 2'd0) && (blk_eff != BLK_LAST)) begin
        blk_cnt  <= blk_eff + 1'b1;
        comp_cnt <= 2'd0;
        mcu_cnt  <= mcu_eff;
      end else begin
        blk_cnt  <= '0;
        comp_cnt <= comp_eff + 2'd1;
        mcu_cnt  <= mcu_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_diff     <= '0;
      out_cat      <= '0;
      out_comp     <= '0;
      out_rst      <= 1'b0;
      out_mcu_last <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_diff     <= diff;
      out_cat      <= cat;
      out_comp     <= comp_eff;
      out_rst      <= rst_pend && !sof;
      out_mcu_last <= mcu_last;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dc_dpcm_encoder.sv
// Scoreboard bench: two encoders (restarts off / every MCU) share one input stream.
module tb_dc_dpcm_encoder;
  localparam int DW = 11, NC = 3, LB = 4;

  logic clk = 1'b0, reset = 1'b1, sof = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [DW-1:0] in_dc = '0;
  logic in_ready0, out_valid0, out_rst0, out_last0;
  logic in_ready1, out_valid1, out_rst1, out_last1;
  logic signed [DW:0] out_diff0, out_diff1;
  logic [3:0] out_cat0, out_cat1;
  logic [1:0] out_comp0, out_comp1;

  always #5 clk = ~clk;

  dc_dpcm_encoder #(.DATA_W(DW), .NUM_COMP(NC), .LUMA_BLOCKS(LB), .RST_INTERVAL(0)) u_dut0 (
    .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .in_ready(in_ready0),
    .in_dc(in_dc), .out_valid(out_valid0), .out_ready(out_ready), .out_diff(out_diff0),
    .out_cat(out_cat0), .out_comp(out_comp0), .out_rst(out_rst0), .out_mcu_last(out_last0));

  dc_dpcm_encoder #(.DATA_W(DW), .NUM_COMP(NC), .LUMA_BLOCKS(LB), .RST_INTERVAL(1)) u_dut1 (
    .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .in_ready(in_ready1),
    .in_dc(in_dc), .out_valid(out_valid1), .out_ready(out_ready), .out_diff(out_diff1),
    .out_cat(out_cat1), .out_comp(out_comp1), .out_rst(out_rst1), .out_mcu_last(out_last1));

  typedef struct { int diff; int cat; int comp; bit rst; bit last; } exp_t;
  exp_t q0[$], q1[$];

  int n_chk = 0, n_fail = 0, last_wait = 0;
  int m_pred[2][4];
  int m_blk[2], m_comp[2], m_mcu[2];
  bit m_rp[2];
  int ri[2] = '{0, 1};

  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void mclr(int i);
    for (int k = 0; k < 4; k++) m_pred[i][k] = 0;
    m_blk[i] = 0; m_comp[i] = 0; m_mcu[i] = 0; m_rp[i] = 1'b0;
  endfunction

  function automatic exp_t model(int i, bit s, int dc);
    exp_t e;
    int a;
    if (s) mclr(i);
    e.rst  = m_rp[i];
    e.comp = m_comp[i];
    e.diff = dc - m_pred[i][m_comp[i]];
    a = (e.diff < 0) ? -e.diff : e.diff;
    e.cat = 0;
    while (a != 0) begin e.cat++; a = a >> 1; end
    e.last = (m_comp[i] == NC-1) && (m_comp[i] != 0 || m_blk[i] == LB-1);
    m_pred[i][m_comp[i]] = dc;
    m_rp[i] = 1'b0;
    if (e.last) begin
      m_blk[i] = 0; m_comp[i] = 0; m_mcu[i]++;
      if (ri[i] != 0 && m_mcu[i] == ri[i]) begin
        m_mcu[i] = 0; m_rp[i] = 1'b1;
        for (int k = 0; k < 4; k++) m_pred[i][k] = 0;
      end
    end else if (m_comp[i] == 0 && m_blk[i] < LB-1) m_blk[i]++;
    else begin m_comp[i]++; m_blk[i] = 0; end
    return e;
  endfunction

  task automatic score(string nm, exp_t e, logic signed [DW:0] d, logic [3:0] c,
                       logic [1:0] cp, logic r, logic l);
    chk({nm, "_diff"}, d, e.diff);
    chk({nm, "_cat"},  c, e.cat);
    chk({nm, "_comp"}, cp, e.comp);
    chk({nm, "_rst"},  r, e.rst);
    chk({nm, "_last"}, l, e.last);
  endtask

  // Mid-cycle monitor: a handshake seen here completes at the next rising edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      q0.delete(); q1.delete(); mclr(0); mclr(1);
    end else begin
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("sb0_empty", q0.size(), 1);
        else score("sb0", q0.pop_front(), out_diff0, out_cat0, out_comp0, out_rst0, out_last0);
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("sb1_empty", q1.size(), 1);
        else score("sb1", q1.pop_front(), out_diff1, out_cat1, out_comp1, out_rst1, out_last1);
      end
      if (in_valid && in_ready0) begin
        q0.push_back(model(0, sof, int'(in_dc)));
        q1.push_back(model(1, sof, int'(in_dc)));
      end
    end
  end

  task automatic send(bit s, int dc);
    bit acc = 1'b0;
    int n = 0;
    sof = s; in_dc = dc[DW-1:0]; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("send_timeout", n, 0);
    last_wait = n;
    in_valid = 1'b0; sof = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_diff",  out_diff0, 0);
    chk("rst_out_cat",   out_cat0, 0);
    chk("rst_out_last",  out_last1, 0);
    chk("rst_in_ready",  in_ready0, 1);
    @(posedge clk); #1;

    // MCU 1 and 2, default schedule
    send(1'b1, 10);
    chk("t1_diff", out_diff0, 10);
    chk("t1_cat",  out_cat0, 4);
    send(0, 12); send(0, 12); send(0, 9); send(0, -5);
    chk("t1_cb_comp", out_comp0, 1);
    send(0, 3);
    chk("t1_cr_last", out_last0, 1);
    chk("t1_cr_diff", out_diff0, 3);
    send(0, 9);
    chk("t2_diff0", out_diff0, 0);
    chk("t2_diff1_restart", out_diff1, 9);
    chk("t2_rst1", out_rst1, 1);
    send(0, 9); send(0, 9); send(0, 9); send(0, -5); send(0, 3);
    chk("t2_cr_cat", out_cat0, 0);

    // Restart every MCU on dut1
    send(1'b1, 7); send(0, 7); send(0, 7); send(0, 7); send(0, 1); send(0, 1);
    send(0, 7);
    chk("t3_diff1", out_diff1, 7);
    chk("t3_rst1",  out_rst1, 1);
    chk("t3_diff0", out_diff0, 0);
    chk("t3_rst0",  out_rst0, 0);
    send(0, 7); send(0, 7); send(0, 7); send(0, 1);
    chk("t3_cb_diff1", out_diff1, 1);
    send(0, 1);

    // Extremes
    send(1'b1, 1023);
    chk("t4_diff_max", out_diff0, 1023);
    chk("t4_cat_max",  out_cat0, 10);
    send(0, -1024);
    chk("t4_diff_min", out_diff0, -2047);
    chk("t4_cat_min",  out_cat0, 11);

    // Backpressure with input held
    out_ready = 1'b0;
    sof = 1'b0; in_dc = 11'sd100; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_in_ready", in_ready0, 0);
      chk("t5_hold_diff", out_diff0, -2047);
      chk("t5_hold_valid", out_valid0, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(0, 100);
    for (int k = 0; k < 4; k++) begin
      send(0, k * 50 - 60);
      chk("t5_tput", last_wait, 1);
    end

    // sof mid-MCU
    send(0, 3);
    send(1'b1, 6);
    chk("sof_mid_diff", out_diff0, 6);
    chk("sof_mid_comp", out_comp0, 0);

    // Reset mid-MCU
    send(1'b1, 1); send(0, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid0_in_reset", out_valid0, 0);
    chk("t6_valid1_in_reset", out_valid1, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    send(1'b1, 5);
    chk("t6_diff", out_diff0, 5);
    chk("t6_comp", out_comp0, 0);

    // Random stream with random backpressure and occasional sof
    fork
      begin
        repeat (400) begin @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0); end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send($urandom_range(0, 15) == 0, int'($urandom_range(0, 2047)) - 1024);
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end
endmodule
